mux_nway_arb: RTL

- Parametrised successor to the datapath 2:1 select mux.
- Selects one of CHANNELS input words of WIDTH bits, by explicit select or by round-robin arbitration.
- Registers the result behind a valid/ready handshake.
- Used at multi-source convergence points (writeback source select, shared-bus requesters) where sources present data asynchronously to the consumer.

---
 rtl/mux_nway_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mux_nway_arb.sv
// -----------------------------------------------------------------------------
// mux_nway_arb
//
// Purpose:
//   N-way word selector with a registered valid/ready output stage. One of
//   CHANNELS input words is chosen either by an explicit channel index
//   (mode = 0) or by a round-robin arbiter (mode = 1). The chosen word and its
//   channel index are captured into the output register on a transfer.
//
// Parameters:
//   WIDTH     data width of each channel and of out_data
//   CHANNELS  number of input channels (2..16)
//   SEL_W     width of the select / channel-index fields
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready, one-hot or zero
//   mode        0 = fixed select by sel, 1 = round-robin
//   sel         channel index used in fixed-select mode
//   out_data    registered selected word
//   out_chan    index of the channel that produced out_data
//   out_valid   out_data / out_chan hold a word
//   out_parity  (only with MUX_NWAY_PARITY_EN) XOR reduction of out_data
//   out_ready   consumer accepts the word this cycle
//
// Optional feature macro: MUX_NWAY_PARITY_EN
//   When defined, an out_parity output is added and registered alongside
//   out_data. When undefined, the port and all parity logic are absent.
// -----------------------------------------------------------------------------
module mux_nway_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
`ifdef MUX_NWAY_PARITY_EN
    output logic                      out_parity,
`endif
    input  logic                      out_ready
);

    // Channel count in the (SEL_W+1)-bit domain used for wrap-around sums.
    localparam logic [SEL_W:0]   CHAN_EXT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] ONE_IDX  = SEL_W'(1);

`ifdef MUX_NWAY_PARITY_EN
    // Even parity of a data word (XOR reduction).
    function automatic logic calc_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] ptr_r;
`ifdef MUX_NWAY_PARITY_EN
    logic             out_parity_r;
`endif

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic             load_s;
    logic             found_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [SEL_W:0]   cand_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic             xfer_s;

    // The output register can accept a new word when empty or being drained.
    assign load_s = !out_valid_r || out_ready;

    // Grant selection: fixed index or round-robin search starting at ptr_r.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        cand_s      = {(SEL_W+1){1'b0}};
        if (mode == 1'b0) begin
            // Comparing sel against every legal index means an out-of-range
            // select simply matches nothing, with no out-of-bounds access.
            for (int k = 0; k < CHANNELS; k++) begin
                if ((sel == SEL_W'(k)) && in_valid[k]) begin
                    found_s     = 1'b1;
                    grant_idx_s = SEL_W'(k);
                end else begin
                    found_s     = found_s;
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            // Visit ptr, ptr+1, ... wrapping at CHANNELS; first valid wins.
            // ptr_r < CHANNELS so the sum fits in SEL_W+1 bits.
            for (int k = 0; k < CHANNELS; k++) begin
                cand_s = {1'b0, ptr_r} + (SEL_W+1)'(k);
                if (cand_s >= CHAN_EXT) begin
                    cand_s = cand_s - CHAN_EXT;
                end else begin
                    cand_s = cand_s;
                end
                if (!found_s && in_valid[cand_s[SEL_W-1:0]]) begin
                    found_s     = 1'b1;
                    grant_idx_s = cand_s[SEL_W-1:0];
                end else begin
                    found_s     = found_s;
                    grant_idx_s = grant_idx_s;
                end
            end
        end
    end

    // Data mux for the granted channel and the one-hot ready vector.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        in_ready_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (found_s && (grant_idx_s == SEL_W'(k))) begin
                sel_data_s    = in_data[k*WIDTH +: WIDTH];
                in_ready_s[k] = load_s;
            end else begin
                in_ready_s[k] = 1'b0;
            end
        end
    end

    // A grant is only issued to a valid channel, so grant plus load is a transfer.
    assign xfer_s = found_s && load_s;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------

    // Output register: load on transfer, clear valid on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= sel_data_s;
            out_chan_r  <= grant_idx_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            // Drain without replacement: data and channel keep last values.
            out_data_r  <= out_data_r;
            out_chan_r  <= out_chan_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_chan_r  <= out_chan_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer: advances past the winner only on round-robin transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (xfer_s && (mode == 1'b1)) begin
            if (grant_idx_s == LAST_IDX) begin
                ptr_r <= {SEL_W{1'b0}};
            end else begin
                ptr_r <= grant_idx_s + ONE_IDX;
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

`ifdef MUX_NWAY_PARITY_EN
    // Parity register tracks out_data: loaded with it, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_r <= 1'b0;
        end else if (xfer_s) begin
            out_parity_r <= calc_parity(sel_data_s);
        end else begin
            out_parity_r <= out_parity_r;
        end
    end

    assign out_parity = out_parity_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule
